// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access-size codes, FSM states and
// the legality rule for a request.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] offset);
    case (f3)
      F3_B, F3_BU: return 1'b1;
      F3_H, F3_HU: return ~offset[0];
      F3_W:        return offset == 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/halfword of a returned cache word and sign- or
// zero-extends it to the full register width.
module load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       offset,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    result = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   result = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_H:    result = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   result = {{(WIDTH-16){1'b0}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns pipeline load/store controls into one
// handshaked word access on the data cache and stalls until it completes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] write_data,
  output logic             stall,
  output logic [WIDTH-1:0] read_data,
  output logic             access_error,
  output logic             cache_req,
  output logic             cache_we,
  output logic [WIDTH-1:0] cache_addr,
  output logic [WIDTH-1:0] cache_wdata,
  output logic [BYTES-1:0] cache_byte_en,
  input  logic [WIDTH-1:0] cache_rdata,
  input  logic             cache_ready
);

  lsu_state_t       state, state_next;
  logic             req_any, legal, new_req, load_done;
  logic [1:0]       offset_p1;
  logic [2:0]       funct3_p1;
  logic             store_p1;
  logic [WIDTH-1:0] load_result;

  function automatic logic [BYTES-1:0] store_byte_en(input logic [2:0] f3, input logic [1:0] offset);
    case (f3[1:0])
      2'b00:   return {{(BYTES-1){1'b0}}, 1'b1} << offset;
      2'b01:   return {{(BYTES-2){1'b0}}, 2'b11} << {offset[1], 1'b0};
      default: return '1;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] store_wdata(input logic [2:0] f3, input logic [WIDTH-1:0] data);
    case (f3[1:0])
      2'b00:   return {BYTES{data[7:0]}};
      2'b01:   return {(WIDTH/16){data[15:0]}};
      default: return data;
    endcase
  endfunction

  assign req_any   = mem_read | mem_write;
  assign legal     = access_legal(funct3, addr[1:0]);
  assign new_req   = (state == IDLE) & req_any & legal;
  assign load_done = (state == BUSY) & cache_ready & ~store_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    access_error = 1'b0;
    cache_req    = 1'b0;
    cache_we     = 1'b0;
    case (state)
      IDLE: begin
        if (new_req) begin
          stall      = 1'b1;
          state_next = BUSY;
        end else if (req_any) begin
          access_error = 1'b1;
        end
      end
      BUSY: begin
        stall     = 1'b1;
        cache_req = 1'b1;
        cache_we  = store_p1;
        if (cache_ready) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // p1: request fields captured when the access is accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_p1     <= '0;
      funct3_p1     <= '0;
      store_p1      <= 1'b0;
      cache_addr    <= '0;
      cache_wdata   <= '0;
      cache_byte_en <= '0;
    end else if (new_req) begin
      offset_p1     <= addr[1:0];
      funct3_p1     <= funct3;
      store_p1      <= mem_write & ~mem_read;
      cache_addr    <= {addr[WIDTH-1:2], 2'b00};
      cache_wdata   <= store_wdata(funct3, write_data);
      cache_byte_en <= (mem_write & ~mem_read) ? store_byte_en(funct3, addr[1:0]) : '0;
    end
  end

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .funct3 (funct3_p1),
    .offset (offset_p1),
    .word   (cache_rdata),
    .result (load_result)
  );

  // p2: extended load result, held until the next load completes
  always_ff @(posedge clk) begin
    if (rst)            read_data <= '0;
    else if (load_done) read_data <= load_result;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-cycle compare against a
// transaction-level model plus literal checks on the documented scenarios.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, cache_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data, cache_rdata;
  logic        stall, access_error, cache_req, cache_we;
  logic [31:0] read_data, cache_addr, cache_wdata;
  logic [3:0]  cache_byte_en;

  load_store_unit dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data), .stall(stall),
    .read_data(read_data), .access_error(access_error), .cache_req(cache_req),
    .cache_we(cache_we), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_byte_en(cache_byte_en), .cache_rdata(cache_rdata), .cache_ready(cache_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic chk_en = 1'b0;
  logic exp_stall, exp_err, exp_req, exp_we;
  logic [31:0] exp_rd, exp_addr, exp_wdata;
  logic [3:0] exp_be;
  int stall_cnt = 0;
  int req_cnt = 0;
  logic [31:0] last_st_addr, last_st_wdata;
  logic [3:0] last_st_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_legal(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    return (int'(a) % size_of(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
    int n;
    logic [31:0] v, mask;
    n = size_of(f3);
    v = word >> (8 * int'(a));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    logic [7:0] t;
    t = 8'((1 << size_of(f3)) - 1) << a;
    return t[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = size_of(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("access_error", 32'(access_error), 32'(exp_err));
      check("cache_req", 32'(cache_req), 32'(exp_req));
      check("read_data", read_data, exp_rd);
      if (exp_req) begin
        check("cache_we", 32'(cache_we), 32'(exp_we));
        check("cache_addr", cache_addr, exp_addr);
        check("cache_byte_en", 32'(cache_byte_en), 32'(exp_be));
        if (exp_we) check("cache_wdata", cache_wdata, exp_wdata);
      end
      if (stall === 1'b1) stall_cnt++;
      if (cache_req === 1'b1) req_cnt++;
      if (cache_req === 1'b1 && cache_we === 1'b1) begin
        last_st_addr  = cache_addr;
        last_st_wdata = cache_wdata;
        last_st_be    = cache_byte_en;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int nwait);
    logic lg, st;
    lg = model_legal(f3, a[1:0]);
    st = wr & ~rd;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; write_data = wd; cache_ready = 1'b0;
    exp_stall = lg; exp_err = ~lg; exp_req = 1'b0; exp_we = 1'b0;
    tick();
    if (lg) begin
      for (int w = 0; w <= nwait; w++) begin
        cache_ready = (w == nwait);
        cache_rdata = (w == nwait) ? rdata : 32'h5A5A_C3C3;
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = st;
        exp_addr = {a[31:2], 2'b00};
        exp_be = st ? model_be(f3, a[1:0]) : 4'b0000;
        exp_wdata = model_wdata(f3, wd);
        tick();
      end
      cache_ready = 1'b0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
      if (!st) exp_rd = model_load(f3, a[1:0], rdata);
      tick();
    end
    mem_read = 1'b0; mem_write = 1'b0;
    exp_stall = 1'b0; exp_err = 1'b0; exp_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = '0;
    write_data = '0; cache_rdata = '0; cache_ready = 1'b0;
    exp_stall = 1'b0; exp_err = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_rd = '0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    last_st_addr = '0; last_st_wdata = '0; last_st_be = '0;
    tick();
    chk_en = 1'b1;
    check("reset_addr", cache_addr, 32'h0);
    check("reset_be", 32'(cache_byte_en), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // model pins
    check("pin_model_lb", model_load(3'b000, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
    check("pin_model_sh_be", 32'(model_be(3'b001, 2'd2)), 32'h0000_000C);

    stall_cnt = 0;
    access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    check("lb_value", read_data, 32'hFFFF_FF80);
    check("lb_stall_cycles", 32'(stall_cnt), 32'd2);

    access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0);
    check("lhu_value", read_data, 32'h0000_BEEF);
    access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0);
    check("lh_value", read_data, 32'hFFFF_BEEF);

    access(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0);
    check("sb_be", 32'(last_st_be), 32'h0000_0008);
    check("sb_wdata", last_st_wdata, 32'hA5A5_A5A5);
    check("sb_addr", last_st_addr, 32'h0000_0010);
    check("sb_keeps_read_data", read_data, 32'hFFFF_BEEF);
    access(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 32'h0, 1);
    check("sh_be", 32'(last_st_be), 32'h0000_000C);
    check("sh_wdata", last_st_wdata, 32'h1234_1234);
    access(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 0);
    check("sw_be", 32'(last_st_be), 32'h0000_000F);
    check("sw_wdata", last_st_wdata, 32'hDEAD_BEEF);

    // illegal requests: no cache traffic, read_data untouched
    req_cnt = 0;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0);
    access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
    access(1'b0, 1'b1, 3'b001, 32'h0000_0013, 32'h0000_FFFF, 32'h0, 0);
    access(1'b1, 1'b0, 3'b111, 32'h0000_0100, 32'h0, 32'h0, 0);
    check("illegal_no_req", 32'(req_cnt), 32'd0);
    check("illegal_keeps_read_data", read_data, 32'hFFFF_BEEF);

    access(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_9A00, 2);
    check("lbu_value", read_data, 32'h0000_009A);

    stall_cnt = 0;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 4);
    check("lw_wait_value", read_data, 32'hCAFE_F00D);
    check("lw_wait_stall_cycles", 32'(stall_cnt), 32'd6);

    // read and write together behave as a load
    access(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'hFFFF_FFFF, 32'h1122_3344, 0);
    check("rw_is_load", read_data, 32'h1122_3344);

    // reset in the second BUSY cycle discards the access
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040; cache_ready = 1'b0;
    exp_stall = 1'b1; exp_err = 1'b0; exp_req = 1'b0;
    tick();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0040; exp_be = 4'b0000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_read = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_rd = 32'h0;
    check("rst_busy_req", 32'(cache_req), 32'h0);
    check("rst_busy_read_data", read_data, 32'h0);
    cache_ready = 1'b1; cache_rdata = 32'hFFFF_FFFF;
    tick();
    cache_ready = 1'b0;
    tick();
    check("idle_ready_ignored", read_data, 32'h0);
    check("idle_ready_no_stall", 32'(stall), 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
